// File: rtl/hard_intr_ctrl.sv
// rtl/hard_intr_ctrl.sv - edge-latched, maskable, one-at-a-time hardware interrupt controller
module hard_intr_ctrl #(
    parameter int P_NUM_SRC   = 8,
    parameter int P_CODE_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [P_NUM_SRC-1:0]   i_irq,
    output logic                   o_h_intr,
    output logic [P_CODE_BITS-1:0] o_h_intr_code,
    input  logic                   i_intr_finish,
    input  logic [1:0]             i_addr,
    input  logic                   i_read,
    input  logic                   i_write,
    input  logic [31:0]            i_writedata,
    output logic [31:0]            o_readdata,
    output logic                   o_readdatavalid
);

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SERVICE} state_t;

    state_t                 state, state_nxt;
    logic [P_NUM_SRC-1:0]   irq_prev, pending, pending_nxt, mask;
    logic [P_NUM_SRC-1:0]   rise, req, win_bit;
    logic [P_CODE_BITS-1:0] win_code;
    logic [31:0]            count, rd_mux;
    logic                   grant;
    logic                   unused_wdata;

    assign unused_wdata = ^i_writedata[31:P_NUM_SRC];

    always_comb begin
        rise     = i_irq & ~irq_prev;
        req      = pending & mask;
        win_bit  = '0;
        win_code = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = P_NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_bit    = '0;
                win_bit[i] = 1'b1;
                win_code   = P_CODE_BITS'(i + 1);
            end
        end

        state_nxt = state;
        grant     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    state_nxt = S_FIRE;
                end
            end
            S_FIRE:    state_nxt = S_SERVICE;
            S_SERVICE: if (i_intr_finish) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        // Clears first, new edges last: a set on the same bit always survives.
        pending_nxt = pending;
        if (i_write && i_addr == 2'd0)
            pending_nxt = pending_nxt & ~i_writedata[P_NUM_SRC-1:0];
        if (grant)
            pending_nxt = pending_nxt & ~win_bit;
        pending_nxt = pending_nxt | rise;

        case (i_addr)
            2'd0:    rd_mux = {{(32-P_NUM_SRC){1'b0}}, pending};
            2'd1:    rd_mux = {{(32-P_NUM_SRC){1'b0}}, mask};
            2'd2:    rd_mux = {{(32-P_CODE_BITS){1'b0}}, o_h_intr_code};
            default: rd_mux = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            irq_prev        <= i_irq;
            pending         <= '0;
            mask            <= '0;
            count           <= '0;
            o_h_intr        <= 1'b0;
            o_h_intr_code   <= '0;
            o_readdata      <= '0;
            o_readdatavalid <= 1'b0;
        end else begin
            state    <= state_nxt;
            irq_prev <= i_irq;
            pending  <= pending_nxt;
            if (i_write && i_addr == 2'd1)
                mask <= i_writedata[P_NUM_SRC-1:0];
            // Registered from the grant so the pulse lines up exactly with the FIRE state.
            o_h_intr <= grant;
            if (grant)
                o_h_intr_code <= win_code;
            else if (state == S_SERVICE && i_intr_finish)
                o_h_intr_code <= '0;
            if (state == S_FIRE)
                count <= count + 32'd1;
            o_readdatavalid <= i_read;
            o_readdata      <= i_read ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_hard_intr_ctrl.sv
// tb/tb_hard_intr_ctrl.sv - directed self-checking bench for hard_intr_ctrl
module tb_hard_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_irq;
    logic        o_h_intr;
    logic [3:0]  o_h_intr_code;
    logic        i_intr_finish;
    logic [1:0]  i_addr;
    logic        i_read;
    logic        i_write;
    logic [31:0] i_writedata;
    logic [31:0] o_readdata;
    logic        o_readdatavalid;

    int total  = 0;
    int passed = 0;

    hard_intr_ctrl #(.P_NUM_SRC(8), .P_CODE_BITS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_irq           (i_irq),
        .o_h_intr        (o_h_intr),
        .o_h_intr_code   (o_h_intr_code),
        .i_intr_finish   (i_intr_finish),
        .i_addr          (i_addr),
        .i_read          (i_read),
        .i_write         (i_write),
        .i_writedata     (i_writedata),
        .o_readdata      (o_readdata),
        .o_readdatavalid (o_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        i_addr = addr;
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        data   = o_readdatavalid ? o_readdata : 32'hDEAD_BEEF;
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        i_addr      = addr;
        i_writedata = data;
        i_write     = 1'b1;
        tick();
        i_write     = 1'b0;
    endtask

    task automatic finish_pulse();
        i_intr_finish = 1'b1;
        tick();
        i_intr_finish = 1'b0;
    endtask

    task automatic wait_pulse(input int max, output int cycles);
        cycles = -1;
        for (int n = 1; n <= max; n++) begin
            tick();
            if (o_h_intr) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          seen;

        rst = 1'b0; i_irq = 8'h04; i_intr_finish = 1'b0;
        i_addr = 2'd0; i_read = 1'b0; i_write = 1'b0; i_writedata = 32'd0;
        tick(); tick();
        check("rst_intr", {31'd0, o_h_intr}, 32'd0);
        check("rst_code", {28'd0, o_h_intr_code}, 32'd0);
        check("rst_rdv", {31'd0, o_readdatavalid}, 32'd0);
        check("rst_rdata", o_readdata, 32'd0);

        // 1: line already high through reset gives no edge
        rst = 1'b1;
        reg_write(2'd1, 32'hFF);
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (o_h_intr) seen++;
        end
        check("t1_no_pulse", seen, 0);
        reg_read(2'd0, rd); check("t1_pending", rd, 32'h0);
        reg_read(2'd1, rd); check("t1_mask", rd, 32'hFF);
        tick();
        check("t1_rdv_idle", {31'd0, o_readdatavalid}, 32'd0);

        // 2: single edge on bit2
        i_irq = 8'h00; tick();
        i_irq = 8'h04; tick();
        i_irq = 8'h00;
        reg_read(2'd0, rd);
        check("t2_pending", rd, 32'h04);
        check("t2_pulse", {31'd0, o_h_intr}, 32'd1);
        check("t2_code", {28'd0, o_h_intr_code}, 32'd3);
        tick();
        check("t2_pulse_end", {31'd0, o_h_intr}, 32'd0);
        reg_read(2'd2, rd); check("t2_active", rd, 32'd3);
        reg_read(2'd3, rd); check("t2_count", rd, 32'd1);
        reg_read(2'd0, rd); check("t2_pending_clr", rd, 32'h0);
        finish_pulse();
        reg_read(2'd2, rd); check("t2_active_fin", rd, 32'd0);

        // 3: simultaneous edges on bits 5 and 1, lowest index first
        i_irq = 8'h22; tick();
        i_irq = 8'h00;
        wait_pulse(10, cyc);
        check("t3_lat1", cyc, 1);
        check("t3_code1", {28'd0, o_h_intr_code}, 32'd2);
        tick(); tick();
        finish_pulse();
        check("t3_idle_gap", {31'd0, o_h_intr}, 32'd0);
        check("t3_idle_code", {28'd0, o_h_intr_code}, 32'd0);
        tick();
        check("t3_pulse2", {31'd0, o_h_intr}, 32'd1);
        check("t3_code2", {28'd0, o_h_intr_code}, 32'd6);
        tick();
        reg_read(2'd3, rd); check("t3_count", rd, 32'd3);
        finish_pulse();

        // 4: masked edge stays pending until unmasked
        reg_write(2'd1, 32'h00);
        i_irq = 8'h01; tick();
        i_irq = 8'h00;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (o_h_intr) seen++;
        end
        check("t4_masked", seen, 0);
        reg_read(2'd0, rd); check("t4_pending", rd, 32'h01);
        reg_write(2'd1, 32'h01);
        check("t4_no_pulse_yet", {31'd0, o_h_intr}, 32'd0);
        tick();
        check("t4_pulse", {31'd0, o_h_intr}, 32'd1);
        check("t4_code", {28'd0, o_h_intr_code}, 32'd1);
        tick();

        // 5: edge and W1C on bit3 in the same cycle during service
        reg_write(2'd1, 32'hFF);
        i_irq = 8'h08; i_addr = 2'd0; i_writedata = 32'h08; i_write = 1'b1;
        tick();
        i_irq = 8'h00; i_write = 1'b0;
        reg_read(2'd0, rd); check("t5_pending", rd, 32'h08);
        check("t5_still_svc", {28'd0, o_h_intr_code}, 32'd1);
        finish_pulse();
        wait_pulse(10, cyc);
        check("t5_lat", cyc, 1);
        check("t5_code", {28'd0, o_h_intr_code}, 32'd4);
        tick();

        // edge and winner-clear on bit6 in the same cycle
        i_irq = 8'h40; tick();
        i_irq = 8'h00;
        i_intr_finish = 1'b1; tick(); i_intr_finish = 1'b0;
        i_irq = 8'h40; tick();
        i_irq = 8'h00;
        check("t5b_code", {28'd0, o_h_intr_code}, 32'd7);
        reg_read(2'd0, rd); check("t5b_pending", rd, 32'h40);
        reg_read(2'd3, rd); check("t5b_count", rd, 32'd6);

        // 6: reset during service
        rst = 1'b0; tick(); rst = 1'b1;
        check("t6_code", {28'd0, o_h_intr_code}, 32'd0);
        check("t6_intr", {31'd0, o_h_intr}, 32'd0);
        reg_read(2'd0, rd); check("t6_pending", rd, 32'h0);
        reg_read(2'd1, rd); check("t6_mask", rd, 32'h0);
        reg_read(2'd3, rd); check("t6_count", rd, 32'd0);
        reg_write(2'd1, 32'hFF);
        finish_pulse();
        reg_read(2'd2, rd); check("t6_active", rd, 32'd0);
        i_irq = 8'h02; tick();
        i_irq = 8'h00;
        wait_pulse(10, cyc);
        check("t6_lat", cyc, 1);
        check("t6_code2", {28'd0, o_h_intr_code}, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
